psum_requant_stage: RTL and testbench

Downstream stage of the 4×12 conv-layer-2 PE array. It consumes the array's 12-lane, 16-bit column partial sums and accumulates them over `PASSES` input-channel groups. It then applies ReLU, round-shift requantization and 8-bit saturation, and emits a 96-bit ofmap column in the same 8-bit-per-lane format the PE arrays take as `Ifmap_shift_in`. Input and output use valid/ready handshakes, so the array and the ofmap buffer can stall independently.

---
 rtl/psum_stage_pkg.sv | 30 +++
 rtl/psum_lane_requant.sv | 29 ++
 rtl/psum_requant_stage.sv | 89 ++++++++
 tb/tb_psum_requant_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_stage_pkg.sv
// Shared constants, FSM state type and lane-slice helpers for the
// partial-sum requantization stage.
package psum_stage_pkg;

  localparam int LANES = 12;
  localparam int IN_W  = 16;
  localparam int ACC_W = 20;
  localparam int OUT_W = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Debug view of the control state, for checkers and waveform reading.
  typedef struct packed {
    state_t     state;
    logic [3:0] pass_cnt;
  } stage_dbg_t;

  // Lane 0 occupies the most significant slice of each packed bus.
  function automatic int in_msb(input int lane);
    return LANES * IN_W - 1 - IN_W * lane;
  endfunction

  function automatic int out_msb(input int lane);
    return LANES * OUT_W - 1 - OUT_W * lane;
  endfunction

endpackage

// File: rtl/psum_lane_requant.sv
// One lane of requantization: ReLU, round-half-up right shift and
// saturation to the unsigned ofmap width. Purely combinational.
module psum_lane_requant
  import psum_stage_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum,
  input  logic        [3:0]       shift,
  output logic        [OUT_W-1:0] result
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**OUT_W - 1);

  // One extra bit so adding the rounding constant cannot wrap.
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    ext     = {sum[ACC_W-1], sum};
    rnd     = '0;
    if (shift != 4'd0) rnd = (ACC_W+1)'(1) << (shift - 4'd1);
    shifted = (ext + rnd) >>> shift;
    result  = '0;
    if (sum[ACC_W-1] || sum == '0) result = '0;
    else if (shifted > SAT_MAX)    result = '1;
    else                           result = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_requant_stage.sv
// Accumulates PASSES partial-sum beats per tile across all lanes, then
// registers the requantized ofmap column behind a valid/ready output.
module psum_requant_stage
  import psum_stage_pkg::*;
#(
  parameter int PASSES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [3:0]               shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    psum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   ofmap_out,
  output logic                     busy,
  output stage_dbg_t               dbg
);

  // Handshake: a beat moves on a cycle where valid and ready are both high;
  // ready never looks at valid, and valid holds until the beat is taken.
  localparam logic [3:0] LAST = 4'(PASSES - 1);

  state_t                  state;
  logic [3:0]              pass_cnt;
  logic [3:0]              shift_q;
  logic [3:0]              req_shift;
  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [ACC_W-1:0] sum [LANES];
  logic [OUT_W-1:0]        req [LANES];
  logic                    first_pass;
  logic                    last_pass;
  logic                    accept;
  logic                    final_accept;

  assign in_ready     = en & ~rst & ((state == ACC) | out_ready);
  assign accept       = in_valid & in_ready;
  assign first_pass   = (pass_cnt == 4'd0);
  assign last_pass    = (pass_cnt == LAST);
  assign final_accept = accept & last_pass;
  assign req_shift    = first_pass ? shift : shift_q;
  assign dbg          = '{state: state, pass_cnt: pass_cnt};

  // Pass 0 starts from zero so the old accumulator is overwritten, not added.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i] = (first_pass ? '0 : acc[i])
             + ACC_W'($signed(psum_in[in_msb(i) -: IN_W]));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_lane_requant u_requant (
      .sum    (sum[g]),
      .shift  (req_shift),
      .result (req[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      pass_cnt  <= 4'd0;
      shift_q   <= 4'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      ofmap_out <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        pass_cnt <= last_pass ? 4'd0 : pass_cnt + 4'd1;
        busy     <= ~last_pass;
        if (first_pass) shift_q <= shift;
        for (int i = 0; i < LANES; i++) acc[i] <= sum[i];
      end
      if (final_accept) begin
        for (int i = 0; i < LANES; i++) ofmap_out[out_msb(i) -: OUT_W] <= req[i];
        out_valid <= 1'b1;
        state     <= HOLD;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_psum_requant_stage.sv
// Directed and randomized bench for psum_requant_stage with a
// tile-level arithmetic reference model and an expected-result queue.
module tb_psum_requant_stage;
  import psum_stage_pkg::*;

  localparam int PASSES = 4;
  localparam int DW = LANES * IN_W;
  localparam int OW = LANES * OUT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [3:0]    shift = 4'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] psum_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] ofmap_out;
  logic          busy;
  stage_dbg_t    dbg;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;

  logic [OW-1:0] exp_q[$];
  int m_pass = 0;
  int m_shift = 0;
  int m_acc[LANES];

  psum_requant_stage #(.PASSES(PASSES)) dut (
    .clk(clk), .rst(rst), .en(en), .shift(shift), .in_valid(in_valid),
    .in_ready(in_ready), .psum_in(psum_in), .out_valid(out_valid),
    .out_ready(out_ready), .ofmap_out(ofmap_out), .busy(busy), .dbg(dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_lane(input int s, input int sh);
    int r;
    if (s <= 0) return '0;
    r = (s + ((sh != 0) ? (1 << (sh - 1)) : 0)) / (1 << sh);
    return (r > 255) ? 8'd255 : OUT_W'(r);
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[in_msb(i) -: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic logic [OW-1:0] fill_out(input int v);
    logic [OW-1:0] d;
    for (int i = 0; i < LANES; i++) d[out_msb(i) -: OUT_W] = OUT_W'(v);
    return d;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      m_pass = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", ofmap_out, '0);
        else check("scoreboard", ofmap_out, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (m_pass == 0) m_shift = int'(shift);
        for (int i = 0; i < LANES; i++) begin
          int v;
          v = int'($signed(psum_in[in_msb(i) -: IN_W]));
          m_acc[i] = (m_pass == 0) ? v : m_acc[i] + v;
        end
        m_pass++;
        if (m_pass == PASSES) begin
          logic [OW-1:0] e;
          for (int i = 0; i < LANES; i++) e[out_msb(i) -: OUT_W] = ref_lane(m_acc[i], m_shift);
          exp_q.push_back(e);
          m_pass = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] sh);
    int n;
    n = 0;
    in_valid = 1'b1;
    psum_in  = d;
    shift    = sh;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      if (rand_ready) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      n++;
    end
    check("send_ready", OW'(in_ready), OW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] d;

    // reset state
    @(negedge clk);
    check("rst_in_ready", OW'(in_ready), OW'(0));
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_ofmap", ofmap_out, '0);
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_pass_cnt", OW'(dbg.pass_cnt), OW'(0));
    check("rst_state", OW'(dbg.state), OW'(ACC));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", OW'(in_ready), OW'(1));

    // basic accumulation 10+20+30+40
    @(posedge clk); #1;
    send_beat(fill(10), 4'd0);
    check("busy_mid", OW'(busy), OW'(1));
    send_beat(fill(20), 4'd0);
    send_beat(fill(30), 4'd0);
    send_beat(fill(40), 4'd0);
    @(negedge clk);
    check("basic_valid", OW'(out_valid), OW'(1));
    check("basic_ofmap", ofmap_out, fill_out(100));
    @(negedge clk);
    check("basic_valid_pulse", OW'(out_valid), OW'(0));

    // ReLU / saturation / shift=1
    @(posedge clk); #1;
    d = fill(3);
    d[in_msb(0) -: IN_W]  = 16'hFFFB;
    d[in_msb(1) -: IN_W]  = 16'h7FFF;
    d[in_msb(11) -: IN_W] = 16'd64;
    repeat (PASSES) send_beat(d, 4'd1);
    @(negedge clk);
    check("relu_lane0", OW'(ofmap_out[out_msb(0) -: OUT_W]), OW'(0));
    check("sat_lane1", OW'(ofmap_out[out_msb(1) -: OUT_W]), OW'(255));
    check("shift1_lane11", OW'(ofmap_out[out_msb(11) -: OUT_W]), OW'(128));
    check("shift1_lane5", OW'(ofmap_out[out_msb(5) -: OUT_W]), OW'(6));

    // rounding, shift=2: sums 10, 9, 2
    @(posedge clk); #1;
    d = fill(0);
    d[in_msb(0) -: IN_W] = 16'd10;
    d[in_msb(1) -: IN_W] = 16'd9;
    d[in_msb(2) -: IN_W] = 16'd2;
    send_beat(d, 4'd2);
    repeat (PASSES - 1) send_beat(fill(0), 4'd0);
    @(negedge clk);
    check("round_lane0", OW'(ofmap_out[out_msb(0) -: OUT_W]), OW'(3));
    check("round_lane1", OW'(ofmap_out[out_msb(1) -: OUT_W]), OW'(2));
    check("round_lane2", OW'(ofmap_out[out_msb(2) -: OUT_W]), OW'(1));

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int p = 0; p < PASSES; p++) send_beat(fill($urandom_range(0, 90)), 4'd0);
    in_valid = 1'b1;
    psum_in  = fill(7);
    shift    = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", OW'(in_ready), OW'(0));
      check("bp_valid", OW'(out_valid), OW'(1));
      if (exp_q.size() != 0) check("bp_stable", ofmap_out, exp_q[0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", OW'(in_ready), OW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_fall", OW'(out_valid), OW'(0));
    check("bp_pass_cnt", OW'(dbg.pass_cnt), OW'(1));
    @(posedge clk); #1;
    repeat (PASSES - 1) send_beat(fill(7), 4'd0);
    @(negedge clk);
    check("bp_next_tile", ofmap_out, fill_out(28));

    // reset mid-tile
    @(posedge clk); #1;
    send_beat(fill(50), 4'd0);
    send_beat(fill(50), 4'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", OW'(in_ready), OW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", OW'(busy), OW'(0));
    check("rst_mid_valid", OW'(out_valid), OW'(0));
    check("rst_mid_pass_cnt", OW'(dbg.pass_cnt), OW'(0));
    @(posedge clk); #1;
    repeat (PASSES) send_beat(fill(1), 4'd0);
    @(negedge clk);
    check("rst_mid_tile", ofmap_out, fill_out(4));

    // enable gating between pass 1 and pass 2
    @(posedge clk); #1;
    send_beat(fill(5), 4'd0);
    send_beat(fill(6), 4'd0);
    en = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      psum_in = fill(100 + c);
      @(negedge clk);
      check("en_in_ready", OW'(in_ready), OW'(0));
      check("en_pass_cnt", OW'(dbg.pass_cnt), OW'(2));
      @(posedge clk); #1;
    end
    en = 1'b1;
    send_beat(fill(7), 4'd0);
    send_beat(fill(8), 4'd0);
    @(negedge clk);
    check("en_result", ofmap_out, fill_out(26));

    // randomized tiles with random output backpressure
    @(posedge clk); #1;
    rand_ready = 1;
    for (int t = 0; t < 25; t++) begin
      logic [3:0] sh;
      sh = 4'($urandom_range(0, 4));
      for (int p = 0; p < PASSES; p++) begin
        for (int i = 0; i < LANES; i++) d[in_msb(i) -: IN_W] = IN_W'(int'($urandom_range(0, 700)) - 200);
        send_beat(d, sh);
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_empty", OW'(exp_q.size()), OW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
